// File: rtl/check_data_scheduler_pkg.sv
// Shared constants and FSM state type for the check-record scheduler.
// Pure declarations: no logic, no latency.
package check_sched_pkg;
    localparam int         N_CH          = 9;
    localparam logic [7:0] HDR_MARK      = 8'hA5;
    localparam int         WORDS_PER_REC = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;
endpackage

// File: rtl/check_data_scheduler_rr_arbiter.sv
// N-way round-robin priority selector: first request after last_i, wrapping modulo N.
// Purely combinational, zero latency; the grant pointer is owned by the parent.
module rr_arbiter #(
    parameter int N  = 9,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % N]) begin
                idx_o = IW'((int'(last_i) + k) % N);
            end
        end
        gnt_o = '0;
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end
endmodule

// File: rtl/check_data_scheduler.sv
// Serializes one 256-bit check record per grant into a 32-bit FIFO as 1 header + 8 data words.
// Ack one cycle after grant, 9 words in 10 cycles unstalled; fifo_full freezes state and output.
module check_data_scheduler
    import check_sched_pkg::*;
#(
    parameter int N_CH   = 9,
    parameter int REC_W  = 256,
    parameter int WORD_W = 32
) (
    input  logic                  CLK200M,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [N_CH-1:0]       rec_valid,
    input  logic [N_CH*REC_W-1:0] rec_data,
    output logic [N_CH-1:0]       rec_ack,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [WORD_W-1:0]     fifo_din,
    output logic                  busy,
    output logic [3:0]            grant_ch,
    output logic [31:0]           rec_count
);
    state_e             state_q, state_d;
    logic [REC_W-1:0]   rec_q, rec_d;
    logic [3:0]         grant_q, grant_d;
    logic [3:0]         last_q, last_d;
    logic [19:0]        seq_q, seq_d;
    logic [2:0]         idx_q, idx_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [N_CH-1:0]    ack_q, ack_d;

    logic [N_CH-1:0]    arb_gnt;
    logic [3:0]         arb_idx;
    logic               arb_any;

    rr_arbiter #(.N(N_CH), .IW(4)) u_arb (
        .req_i  (rec_valid),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    always_comb begin
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        case (state_q)
            ST_HDR: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = {HDR_MARK, grant_q, seq_q};
            end
            ST_DATA: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = rec_q[(REC_W - 1) - WORD_W * int'(idx_q) -: WORD_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        grant_d = grant_q;
        last_d  = last_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable && arb_any) begin
                    rec_d   = rec_data[int'(arb_idx) * REC_W +: REC_W];
                    grant_d = arb_idx;
                    ack_d   = arb_gnt;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!fifo_full) begin
                    seq_d   = seq_q + 20'd1;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!fifo_full) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'(WORDS_PER_REC - 1)) begin
                        cnt_d   = cnt_q + 32'd1;
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK200M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rec_q   <= '0;
            grant_q <= '0;
            last_q  <= 4'd8;
            seq_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign rec_ack   = ack_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_ch  = grant_q;
    assign rec_count = cnt_q;
endmodule
